rca_64bit: RTL and testbench
============================

Name: rca_64bit

Overview:
- 64-bit ripple-carry adder computing sum = a + b + cin with a carry-out.
- The combinational ripple chain is built from 1-bit full-adder cells.
- Results are captured in an output register, giving one cycle of latency.
- Used as the baseline integer adder in the datapath and as the timing reference for the faster adder variants.

Parameters:
- WIDTH, 64, operand and sum width in bits. It must be at least 1. The 64 case is the one that must be verified.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands on a/b/cin are valid this cycle
- a  input  WIDTH  first operand, unsigned
- b  input  WIDTH  second operand, unsigned
- cin  input  1  carry-in to bit 0
- sum  output  WIDTH  registered low WIDTH bits of a+b+cin
- carry  output  1  registered carry-out of the MSB stage (bit WIDTH of a+b+cin)
- out_valid  output  1  sum/carry hold a result computed from a valid input

Behaviour:
- Reset
  - While rst_n=0, sum=0, carry=0 and out_valid=0 immediately, with no clock required.
  - Release is synchronous to the next clk rising edge, with no special sequencing.
- Datapath
  - WIDTH full-adder cells are chained.
  - c[0]=cin; for each bit i, s[i]=a[i]^b[i]^c[i] and c[i+1]=(a[i]&b[i])|(c[i]&(a[i]^b[i])).
  - The carry-out is c[WIDTH].
  - No carry-lookahead or carry-select logic is allowed. A pure ripple structure is required.
- Registering
  - On each clk rising edge with in_valid=1: sum<=s, carry<=c[WIDTH], out_valid<=1.
  - With in_valid=0: sum and carry hold their previous values and out_valid<=0.
- Latency and throughput
  - Latency is exactly 1 cycle.
  - Throughput is one addition per cycle; back-to-back valid inputs produce back-to-back results.
  - There is no backpressure.
- Arithmetic
  - The adder is unsigned and modulo 2^WIDTH. carry is the unsigned overflow.
  - Signed overflow is not reported. For example, 0x7FFF...F + 1 gives 0x8000...0 with carry=0.
- Boundaries
  - The all-ones + all-ones + 1 case gives sum all-ones and carry=1.
  - A carry generated in bit 0 must propagate through all WIDTH bits within one cycle.
  - rst_n asserted mid-stream discards the in-flight result.
  - X on any input while in_valid=0 must not disturb the held outputs.

Decomposition:
- Package adder_pkg
  - ADDER_WIDTH=64 constant.
  - Typedef word_t (logic [ADDER_WIDTH-1:0]).
- Sub-module full_adder
  - Ports a, b, cin, s, cout; purely combinational.
  - Instantiated WIDTH times in a generate loop inside rca_64bit.
  - The output register lives in rca_64bit.

Test Plan:
- Zero and simple cases: 0+0+0 -> sum 0x0000000000000000, carry 0. 1+1+0 -> 0x0000000000000002, carry 0.
- Full carry propagation: 0xFFFFFFFFFFFFFFFF+0x0000000000000001+0 -> sum 0, carry 1. 0x0000000000000000+0xFFFFFFFFFFFFFFFF+1 -> sum 0, carry 1.
- Maximum inputs: 0xFFFFFFFFFFFFFFFF+0xFFFFFFFFFFFFFFFF+1 -> sum 0xFFFFFFFFFFFFFFFF, carry 1. 0x8000000000000000+0x8000000000000000+1 -> sum 0x0000000000000001, carry 1.
- Mixed patterns:
  - 0xAAAAAAAAAAAAAAAA+0x5555555555555555+0 -> 0xFFFFFFFFFFFFFFFF, carry 0.
  - 0x123456789ABCDEF0+0x0FEDCBA987654321+1 -> 0x2222222222222212, carry 0.
  - 0x123456789ABCDEF0+0x876543210FEDCBA9+0 -> 0x99999999AAAAAA99, carry 0.
  - 0x7FFFFFFFFFFFFFFF+1+0 -> 0x8000000000000000, carry 0.
- Pipeline and control:
  - Drive all cases back-to-back with in_valid=1; each result must appear exactly one cycle later with out_valid=1.
  - Drop in_valid for one cycle; out_valid must fall and sum/carry must hold.
  - Assert rst_n=0 mid-stream; outputs must go to 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared width and word type for the baseline ripple-carry adder.
package adder_pkg;

   localparam int ADDER_WIDTH = 64;

   typedef logic [ADDER_WIDTH-1:0] word_t;

endpackage : adder_pkg

// File: rtl/full_adder.sv
// 1-bit full-adder cell, the building block of the ripple chain.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic p;

   // Sum and carry of one bit position.
   always_comb begin
      p    = a ^ b;
      s    = p ^ cin;
      cout = (a & b) | (cin & p);
   end

endmodule : full_adder

// File: rtl/rca_64bit.sv
// Ripple-carry adder with a registered result: sum/carry = a + b + cin,
// one cycle of latency, one result per cycle, no backpressure.
module rca_64bit
   import adder_pkg::*;
#(
   parameter int WIDTH = ADDER_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             out_valid
);

   logic [WIDTH-1:0] sum_d;
   logic             carry_d;

   logic [WIDTH-1:0] sum_q;
   logic             carry_q;
   logic             out_valid_q;

   // Each stage owns its own carry-in net so the chain is a plain series of
   // cells rather than one self-referencing vector.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic c_in;
      logic c_out;

      if (i == 0) begin : g_first
         assign c_in = cin;
      end else begin : g_rest
         assign c_in = g_bit[i-1].c_out;
      end

      full_adder u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (c_in),
         .s    (sum_d[i]),
         .cout (c_out)
      );
   end

   assign carry_d = g_bit[WIDTH-1].c_out;

   // Capture on valid input; hold the last result otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q       <= '0;
         carry_q     <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= in_valid;
         if (in_valid) begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
         end
      end
   end

   assign sum       = sum_q;
   assign carry     = carry_q;
   assign out_valid = out_valid_q;

endmodule : rca_64bit

// File: tb/tb_rca_64bit.sv
// Directed bench for rca_64bit: hand-computed vectors streamed back to back,
// a valid gap with held outputs, and an asynchronous mid-stream reset.
module tb_rca_64bit;

   localparam int NV = 10;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [63:0] a;
   logic [63:0] b;
   logic        cin;
   logic [63:0] sum;
   logic        carry;
   logic        out_valid;

   int n_vec;
   int n_miss;

   logic [63:0] va [NV];
   logic [63:0] vb [NV];
   logic        vc [NV];
   logic [63:0] es [NV];
   logic        ec [NV];

   rca_64bit #(.WIDTH(64)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sum       (sum),
      .carry     (carry),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_miss++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_result(input string tag, input int k);
      check({tag, "_sum"},   sum,               es[k]);
      check({tag, "_carry"}, {63'd0, carry},    {63'd0, ec[k]});
      check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_vec  = 0;
      n_miss = 0;

      va[0] = 64'h0000000000000000; vb[0] = 64'h0000000000000000; vc[0] = 1'b0;
      es[0] = 64'h0000000000000000; ec[0] = 1'b0;
      va[1] = 64'h0000000000000001; vb[1] = 64'h0000000000000001; vc[1] = 1'b0;
      es[1] = 64'h0000000000000002; ec[1] = 1'b0;
      va[2] = 64'hFFFFFFFFFFFFFFFF; vb[2] = 64'h0000000000000001; vc[2] = 1'b0;
      es[2] = 64'h0000000000000000; ec[2] = 1'b1;
      va[3] = 64'h0000000000000000; vb[3] = 64'hFFFFFFFFFFFFFFFF; vc[3] = 1'b1;
      es[3] = 64'h0000000000000000; ec[3] = 1'b1;
      va[4] = 64'hFFFFFFFFFFFFFFFF; vb[4] = 64'hFFFFFFFFFFFFFFFF; vc[4] = 1'b1;
      es[4] = 64'hFFFFFFFFFFFFFFFF; ec[4] = 1'b1;
      va[5] = 64'h8000000000000000; vb[5] = 64'h8000000000000000; vc[5] = 1'b1;
      es[5] = 64'h0000000000000001; ec[5] = 1'b1;
      va[6] = 64'hAAAAAAAAAAAAAAAA; vb[6] = 64'h5555555555555555; vc[6] = 1'b0;
      es[6] = 64'hFFFFFFFFFFFFFFFF; ec[6] = 1'b0;
      va[7] = 64'h123456789ABCDEF0; vb[7] = 64'h0FEDCBA987654321; vc[7] = 1'b1;
      es[7] = 64'h2222222222222212; ec[7] = 1'b0;
      va[8] = 64'h123456789ABCDEF0; vb[8] = 64'h876543210FEDCBA9; vc[8] = 1'b0;
      es[8] = 64'h99999999AAAAAA99; ec[8] = 1'b0;
      va[9] = 64'h7FFFFFFFFFFFFFFF; vb[9] = 64'h0000000000000001; vc[9] = 1'b0;
      es[9] = 64'h8000000000000000; ec[9] = 1'b0;

      // Reset applied before any clock edge.
      rst_n    = 1'b0;
      in_valid = 1'b0;
      a        = '0;
      b        = '0;
      cin      = 1'b0;
      #1;
      check("reset_sum",   sum,                64'd0);
      check("reset_carry", {63'd0, carry},     64'd0);
      check("reset_valid", {63'd0, out_valid}, 64'd0);

      @(negedge clk);
      rst_n = 1'b1;

      // Back-to-back stream; result k is checked while vector k+1 is driven.
      for (int k = 0; k < NV; k++) begin
         @(negedge clk);
         if (k > 0) check_result($sformatf("vec%0d", k - 1), k - 1);
         in_valid = 1'b1;
         a        = va[k];
         b        = vb[k];
         cin      = vc[k];
      end

      // One-cycle gap with X operands: valid drops, result holds.
      @(negedge clk);
      check_result("vec9", 9);
      in_valid = 1'b0;
      a        = 'x;
      b        = 'x;
      cin      = 1'bx;
      @(negedge clk);
      check("gap_valid", {63'd0, out_valid}, 64'd0);
      check("gap_sum",   sum,                es[9]);
      check("gap_carry", {63'd0, carry},     {63'd0, ec[9]});

      // Resume after the gap.
      in_valid = 1'b1;
      a        = va[8];
      b        = vb[8];
      cin      = vc[8];
      @(negedge clk);
      check_result("resume", 8);

      // In-flight vector discarded by an asynchronous reset between edges.
      a   = va[4];
      b   = vb[4];
      cin = vc[4];
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_sum",   sum,                64'd0);
      check("async_rst_carry", {63'd0, carry},     64'd0);
      check("async_rst_valid", {63'd0, out_valid}, 64'd0);
      @(negedge clk);
      check("rst_hold_sum",   sum,                64'd0);
      check("rst_hold_valid", {63'd0, out_valid}, 64'd0);

      // Release with in_valid low: nothing new is produced.
      rst_n    = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      check("post_rst_valid", {63'd0, out_valid}, 64'd0);
      check("post_rst_sum",   sum,                64'd0);

      // One more vector after reset to confirm normal operation.
      in_valid = 1'b1;
      a        = va[7];
      b        = vb[7];
      cin      = vc[7];
      @(negedge clk);
      check_result("post_rst_vec", 7);
      in_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule : tb_rca_64bit
